reg_bank_16x16: RTL and testbench
=================================

# reg_bank_16x16

Sixteen-entry, 16-bit general-purpose register bank with a program-status register (PSR). It sits directly upstream of the datapath's 16-to-1 operand-select multiplexers and drives all sixteen register values in parallel on r0..r15. It accepts one write-back per cycle from the ALU/load path through a valid/ready handshake. A commanded clear sweep zeroes the bank one register per cycle.

## Interface
Parameters:
- REG_W, 16, register width in bits
- NUM_REGS, 16, number of registers; fixed at 16 to match the 4-bit select

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  write-back request
- wb_ready  out  1  bank can accept a write this cycle
- wb_addr  in  4  destination register index
- wb_data  in  16  write-back data
- flag_we  in  1  load PSR from flags_in
- flags_in  in  5  {N, Z, F, L, C} from the ALU
- clr_req  in  1  start a clear sweep (single-cycle pulse or level)
- clr_busy  out  1  clear sweep in progress
- r0 .. r15  out  16 each  current register contents; wired straight to the operand muxes
- psr  out  5  current PSR {N, Z, F, L, C}

## Operation
- Reset (reset_n low, asynchronous):
  - r0..r15 = 16'h0000, psr = 5'b0
  - state = IDLE, clr_idx = 0
  - wb_ready = 1, clr_busy = 0
- FSM has two states, IDLE and CLEAR.
- IDLE:
  - wb_ready = 1.
  - A write fires when wb_valid & wb_ready: r[wb_addr] <= wb_data.
  - flag_we: psr <= flags_in. Independent of the write port; both may fire in the same cycle.
  - clr_req: go to CLEAR with clr_idx = 0. Any write or flag_we in that same cycle is still performed. The write is not lost; it is later overwritten by the sweep if its index has not yet been cleared.
- CLEAR:
  - wb_ready = 0, clr_busy = 1. flag_we is ignored.
  - Each cycle: r[clr_idx] <= 0 and clr_idx increments.
  - psr is zeroed on the first CLEAR cycle.
  - When clr_idx = 15 is cleared, return to IDLE and wrap clr_idx to 0.
  - clr_req is ignored while in CLEAR; it does not restart the sweep.
- Writes with wb_valid high while wb_ready is low are not accepted. The source must hold wb_addr/wb_data until ready returns (standard valid/ready rules).
- No internal read-after-write bypass: the write-back pipeline stage or hazard logic handles forwarding.

## Timing
- Write latency: a value accepted at edge N appears on r[wb_addr] after edge N; it is visible to the muxes in cycle N+1.
- PSR latency: 1 cycle after flag_we.
- Clear sweep: exactly 16 cycles in CLEAR, with clr_busy high for those 16 cycles. wb_ready is high again in cycle 17 after the clr_req edge.
- Outputs are pure register outputs: no combinational path from any input to r0..r15 or psr.
- wb_ready and clr_busy decode from the state register only.
- reset_n asserted mid-sweep: immediate return to IDLE with everything zeroed. There is no resumption.

## Configuration
- REG_BANK_R0_ZERO_EN
  - Defined: r0 is hard-wired to 16'h0000. Writes to address 0 are accepted (the handshake completes) but discarded. The sweep treats r0 as already clear.
  - Undefined: r0 is an ordinary writable register.

## Structure
- Package regbank_pkg:
  - REG_W, NUM_REGS, ADDR_W = 4, FLAG_W = 5
  - PSR bit-index constants: C=0, L=1, F=2, Z=3, N=4
  - state enum {IDLE, CLEAR}
- One sub-module, reg16_en: 16-bit register with async active-low reset, synchronous clear and enable. It is instantiated 16 times. The bank contributes the write-enable decode, the clear-index decode and the FSM.

## Test plan
- Reset, then write 16'hBEEF to addr 5 with valid=1 → r5 = BEEF next cycle; all other registers 0; wb_ready stays 1.
- Back-to-back writes to addr 3 then addr 3 (1111, 2222) → r3 = 1111 after the first edge and 2222 after the second.
- flag_we with flags_in = 5'b10101 in the same cycle as a write to r7 → psr = 10101 and r7 updated, both one cycle later.
- Fill all registers with nonzero data, pulse clr_req:
  - clr_busy high for exactly 16 cycles, and wb_ready low for the same 16.
  - r[k] reads 0 from cycle k+1 of the sweep.
  - A write held valid through the sweep lands after it.
- Assert reset_n low at sweep cycle 6 → all outputs 0 asynchronously, clr_busy = 0; after release, a clr_req starts a fresh 16-cycle sweep.
- With REG_BANK_R0_ZERO_EN: write FFFF to addr 0 → handshake completes, r0 stays 0000.

Source files
------------

// File: rtl/reg_bank_16x16_pkg.sv
// Shared constants and types for the 16x16 register bank.
// PSR layout is {N, Z, F, L, C}, with C in bit 0.
package regbank_pkg;

    localparam int REG_W    = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int FLAG_W   = 5;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/reg16_en.sv
// Register with async active-low reset, synchronous clear and load enable.
// Clear takes priority over the load enable.
module reg16_en #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_16x16.sv
// 16 x 16-bit register bank with PSR, write-back handshake and clear sweep.
// Build option REG_BANK_R0_ZERO_EN hard-wires r0 to zero.
module reg_bank_16x16
    import regbank_pkg::*;
#(
    parameter int REG_W    = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [REG_W-1:0]  wb_data,
    input  logic              flag_we,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [REG_W-1:0]  r0,
    output logic [REG_W-1:0]  r1,
    output logic [REG_W-1:0]  r2,
    output logic [REG_W-1:0]  r3,
    output logic [REG_W-1:0]  r4,
    output logic [REG_W-1:0]  r5,
    output logic [REG_W-1:0]  r6,
    output logic [REG_W-1:0]  r7,
    output logic [REG_W-1:0]  r8,
    output logic [REG_W-1:0]  r9,
    output logic [REG_W-1:0]  r10,
    output logic [REG_W-1:0]  r11,
    output logic [REG_W-1:0]  r12,
    output logic [REG_W-1:0]  r13,
    output logic [REG_W-1:0]  r14,
    output logic [REG_W-1:0]  r15,
    output logic [FLAG_W-1:0] psr
);

    state_e              state;
    logic [ADDR_W-1:0]   clr_idx;
    logic [FLAG_W-1:0]   psr_q;
    logic                wr_fire;
    logic                sweeping;
    logic [REG_W-1:0]    regs [NUM_REGS];

    assign wb_ready = (state == IDLE);
    assign clr_busy = (state == CLEAR);
    assign sweeping = clr_busy;
    assign wr_fire  = wb_valid & wb_ready;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
`ifdef REG_BANK_R0_ZERO_EN
        if (i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_ff
`else
        begin : g_ff
`endif
            logic we;
            logic clr;

            assign we  = wr_fire & (wb_addr == ADDR_W'(i));
            assign clr = sweeping & (clr_idx == ADDR_W'(i));

            reg16_en #(
                .W (REG_W)
            ) u_reg (
                .clk     (clk),
                .reset_n (reset_n),
                .clr     (clr),
                .en      (we),
                .d       (wb_data),
                .q       (regs[i])
            );
        end
    end

    // A write in the same cycle as clr_req is still taken from IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clr_idx <= '0;
            psr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flag_we) begin
                        psr_q <= flags_in;
                    end
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_idx == '0) begin
                        psr_q <= '0;
                    end
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == {ADDR_W{1'b1}}) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign psr = psr_q;

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];

endmodule

// File: tb/tb_reg_bank_16x16.sv
// Self-checking bench for reg_bank_16x16 against a behavioural model.
// Honours REG_BANK_R0_ZERO_EN the same way as the design build.
module tb_reg_bank_16x16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flag_we;
    logic [4:0]  flags_in;
    logic        clr_req;
    logic        clr_busy;
    logic [15:0] rr [16];
    logic [4:0]  psr;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mref [16];
    logic [4:0]  pref;
    int          sweep_left;
    int          sweep_pos;
    bit          r0_zero;
    int          busy_cycles;

    always #5 clk = ~clk;

    reg_bank_16x16 dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flag_we  (flag_we),
        .flags_in (flags_in),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .r0       (rr[0]),
        .r1       (rr[1]),
        .r2       (rr[2]),
        .r3       (rr[3]),
        .r4       (rr[4]),
        .r5       (rr[5]),
        .r6       (rr[6]),
        .r7       (rr[7]),
        .r8       (rr[8]),
        .r9       (rr[9]),
        .r10      (rr[10]),
        .r11      (rr[11]),
        .r12      (rr[12]),
        .r13      (rr[13]),
        .r14      (rr[14]),
        .r15      (rr[15]),
        .psr      (psr)
    );

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mref[i] = 16'h0;
        pref       = 5'h0;
        sweep_left = 0;
        sweep_pos  = 0;
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic model_edge();
        if (sweep_left == 0) begin
            if (wb_valid && !(r0_zero && wb_addr == 4'd0))
                mref[wb_addr] = wb_data;
            if (flag_we) pref = flags_in;
            if (clr_req) begin
                sweep_left = 16;
                sweep_pos  = 0;
            end
        end else begin
            mref[sweep_pos] = 16'h0;
            if (sweep_pos == 0) pref = 5'h0;
            sweep_pos++;
            sweep_left--;
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".ready"}, 32'(wb_ready),
            32'(sweep_left == 0));
        chk({tag, ".busy"}, 32'(clr_busy),
            32'(sweep_left != 0));
        chk({tag, ".psr"}, 32'(psr), 32'(pref));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s.r%0d", tag, i),
                32'(rr[i]), 32'(mref[i]));
    endtask

    task automatic tick(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0;
        wb_addr  = 4'd0;
        wb_data  = 16'h0;
        flag_we  = 1'b0;
        flags_in = 5'h0;
        clr_req  = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            wb_valid = 1'b1;
            wb_addr  = 4'(i);
            wb_data  = 16'($urandom) | 16'h0001;
            tick("fill");
        end
        wb_valid = 1'b0;
    endtask

    initial begin
`ifdef REG_BANK_R0_ZERO_EN
        r0_zero = 1'b1;
`else
        r0_zero = 1'b0;
`endif
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        wb_valid = 1'b1;
        wb_addr  = 4'd5;
        wb_data  = 16'hBEEF;
        tick("wr_beef");
        chk("r5_beef", 32'(rr[5]), 32'h0000BEEF);
        wb_valid = 1'b0;

        wb_valid = 1'b1;
        wb_addr  = 4'd3;
        wb_data  = 16'h1111;
        tick("b2b_1");
        wb_data  = 16'h2222;
        tick("b2b_2");
        chk("r3_2222", 32'(rr[3]), 32'h00002222);
        wb_valid = 1'b0;

        wb_valid = 1'b1;
        wb_addr  = 4'd7;
        wb_data  = 16'hC0DE;
        flag_we  = 1'b1;
        flags_in = 5'b10101;
        tick("wr_flag");
        chk("psr_10101", 32'(psr), 32'h15);
        idle_inputs();

        for (int n = 0; n < 40; n++) begin
            wb_valid = 1'($urandom);
            wb_addr  = 4'($urandom);
            wb_data  = 16'($urandom);
            flag_we  = 1'($urandom);
            flags_in = 5'($urandom);
            tick("rand_a");
        end
        idle_inputs();

        // Full sweep with a write held valid across it.
        fill_all();
        flag_we  = 1'b1;
        flags_in = 5'b11011;
        clr_req  = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 4'd9;
        wb_data  = 16'h5A5A;
        tick("clr_start");
        clr_req  = 1'b0;
        flag_we  = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 40; n++) begin
            if (!clr_busy) break;
            busy_cycles++;
            tick("sweep");
        end
        chk("sweep_len", 32'(busy_cycles), 32'd16);
        tick("held_wr");
        chk("r9_held", 32'(rr[9]), 32'h00005A5A);
        idle_inputs();

        // Reset at sweep cycle 6.
        fill_all();
        clr_req = 1'b1;
        tick("clr2_start");
        clr_req = 1'b0;
        for (int n = 0; n < 5; n++) tick("sweep2");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fill_all();
        clr_req = 1'b1;
        tick("clr3_start");
        clr_req = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 40; n++) begin
            if (!clr_busy) break;
            busy_cycles++;
            tick("sweep3");
        end
        chk("sweep3_len", 32'(busy_cycles), 32'd16);

        wb_valid = 1'b1;
        wb_addr  = 4'd0;
        wb_data  = 16'hFFFF;
        chk("r0_ready", 32'(wb_ready), 32'd1);
        tick("wr_r0");
        chk("r0_val", 32'(rr[0]),
            r0_zero ? 32'h0 : 32'h0000FFFF);
        idle_inputs();

        for (int n = 0; n < 300; n++) begin
            wb_valid = 1'($urandom);
            wb_addr  = 4'($urandom);
            wb_data  = 16'($urandom);
            flag_we  = 1'($urandom);
            flags_in = 5'($urandom);
            clr_req  = ($urandom_range(0, 24) == 0);
            tick("rand_b");
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
